seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/fixed_point_alu_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_alu_pkg.sv
// Shared constants for the fixed-point ALU units: default operand geometry
// and the sequential divider's state encoding.
package fixed_point_alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 0;

  typedef logic [1:0] div_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width able to hold the values 0..n.
  function automatic int ctr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_in < divisor keeps shifted below 2*divisor, so the result fits WIDTH bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = trial[WIDTH-1:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider producing a WIDTH-bit quotient with
// FRAC fractional bits, one quotient bit per clock.
module seq_divider
  import fixed_point_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = ctr_width(N);
  localparam logic [CW-1:0]    LAST_C = CW'(N - 1);
  localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     dvd;
  logic [N-1:0]     dvd_next;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             sticky;
  logic             sticky_next;
  logic             in_high;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (part),
    .bit_in  (dvd[N-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The first FRAC iterations produce quotient bits above WIDTH-1; any 1 there
  // means the result cannot be represented and Quot saturates.
  generate
    if (FRAC > 0) begin : g_frac
      localparam logic [CW-1:0] FRAC_C = CW'(FRAC);
      assign in_high = (cnt < FRAC_C);
    end else begin : g_nofrac
      assign in_high = 1'b0;
    end
  endgenerate

  // Quotient bits shift into the low end as dividend bits leave the top.
  always_comb begin
    dvd_next    = {dvd[N-2:0], step_q};
    sticky_next = sticky | (in_high & step_q);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= {CW{1'b0}};
      dvd         <= {N{1'b0}};
      part        <= {WIDTH{1'b0}};
      divisor     <= {WIDTH{1'b0}};
      sticky      <= 1'b0;
      Quot        <= {WIDTH{1'b0}};
      Rem         <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            if (B == {WIDTH{1'b0}}) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              Quot        <= ONES;
              Rem         <= A;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else begin
              state   <= ST_RUN;
              busy    <= 1'b1;
              dvd     <= N'(A) << FRAC;
              divisor <= B;
              part    <= {WIDTH{1'b0}};
              cnt     <= {CW{1'b0}};
              sticky  <= 1'b0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          dvd    <= dvd_next;
          part   <= step_rem;
          sticky <= sticky_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_C) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            Quot        <= sticky_next ? ONES : dvd_next[WIDTH-1:0];
            Rem         <= step_rem;
            div_by_zero <= 1'b0;
            overflow    <= sticky_next;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: one FRAC=0 and one FRAC=4 instance,
// directed cases followed by randomized traffic against an arithmetic model.
module tb_seq_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [2];
  logic [7:0] a_in  [2];
  logic [7:0] b_in  [2];
  logic [7:0] quot  [2];
  logic [7:0] rem   [2];
  logic       busy  [2];
  logic       done  [2];
  logic       dbz   [2];
  logic       ovf   [2];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_done [2];
  int busy_lo   [2];
  int busy_hi   [2];
  logic [7:0] held_q [2];
  logic [7:0] held_r [2];
  logic       held_dbz [2];
  logic       held_ovf [2];
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.WIDTH(8), .FRAC(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]), .A(a_in[0]), .B(b_in[0]),
    .Quot(quot[0]), .Rem(rem[0]), .busy(busy[0]), .done(done[0]),
    .div_by_zero(dbz[0]), .overflow(ovf[0])
  );

  seq_divider #(.WIDTH(8), .FRAC(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start[1]), .A(a_in[1]), .B(b_in[1]),
    .Quot(quot[1]), .Rem(rem[1]), .busy(busy[1]), .done(done[1]),
    .div_by_zero(dbz[1]), .overflow(ovf[1])
  );

  // Reference: plain integer arithmetic on A*2^FRAC, saturating at 255.
  function automatic exp_t model(input int frac, input int a, input int b);
    exp_t x;
    int   num;
    int   qq;
    num = a * (1 << frac);
    if (b == 0) begin
      x.q = 8'hFF; x.r = a[7:0]; x.dbz = 1'b1; x.ovf = 1'b0; x.lat = 1;
    end else begin
      qq    = num / b;
      x.r   = 8'(num % b);
      x.dbz = 1'b0;
      x.ovf = (qq > 255);
      x.q   = (qq > 255) ? 8'hFF : 8'(qq);
      x.lat = 8 + frac + 1;
    end
    x.e = 0;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  exp_t mx;
  bit   have;

  // Monitor: pops the scoreboard on every done, otherwise checks held outputs.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy_dut%0d", k), int'(busy[k]),
              int'(cyc >= busy_lo[k] && cyc <= busy_hi[k]));
        if (done[k]) begin
          have = 1'b0;
          if (k == 0 && sb0.size() > 0) begin
            mx = sb0.pop_front(); have = 1'b1;
          end else if (k == 1 && sb1.size() > 0) begin
            mx = sb1.pop_front(); have = 1'b1;
          end
          if (!have) begin
            total++; bad++;
            $display("FAIL unexpected_done_dut%0d: got done=1, required done=0", k);
          end else begin
            check($sformatf("quot_dut%0d", k), int'(quot[k]), int'(mx.q));
            check($sformatf("rem_dut%0d", k), int'(rem[k]), int'(mx.r));
            check($sformatf("dbz_dut%0d", k), int'(dbz[k]), int'(mx.dbz));
            check($sformatf("ovf_dut%0d", k), int'(ovf[k]), int'(mx.ovf));
            check($sformatf("latency_dut%0d", k), cyc - mx.e + 1, mx.lat);
            held_q[k] = mx.q; held_r[k] = mx.r;
            held_dbz[k] = mx.dbz; held_ovf[k] = mx.ovf;
          end
        end else begin
          check($sformatf("hold_quot_dut%0d", k), int'(quot[k]), int'(held_q[k]));
          check($sformatf("hold_rem_dut%0d", k), int'(rem[k]), int'(held_r[k]));
          check($sformatf("hold_dbz_dut%0d", k), int'(dbz[k]), int'(held_dbz[k]));
          check($sformatf("hold_ovf_dut%0d", k), int'(ovf[k]), int'(held_ovf[k]));
        end
      end
    end
  end

  // Start request sampled at the rising edge numbered 'target' (or the next one).
  task automatic issue(input int k, input int a, input int b, input int target, output int e);
    exp_t x;
    @(negedge clk);
    while (cyc + 1 < target) @(negedge clk);
    e = cyc + 1;
    start[k] = 1'b1; a_in[k] = a[7:0]; b_in[k] = b[7:0];
    if (e > last_done[k]) begin
      x = model((k == 0) ? 0 : 4, a, b);
      x.e = e;
      if (k == 0) sb0.push_back(x); else sb1.push_back(x);
      last_done[k] = e + x.lat - 1;
      busy_lo[k]   = e;
      busy_hi[k]   = (b == 0) ? -1 : e + x.lat - 2;
    end
    @(posedge clk);
    #1;
    start[k] = 1'b0; a_in[k] = 8'($urandom); b_in[k] = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_quot_dut%0d", k), int'(quot[k]), 0);
      check($sformatf("rst_rem_dut%0d", k), int'(rem[k]), 0);
      check($sformatf("rst_busy_dut%0d", k), int'(busy[k]), 0);
      check($sformatf("rst_done_dut%0d", k), int'(done[k]), 0);
      check($sformatf("rst_dbz_dut%0d", k), int'(dbz[k]), 0);
      check($sformatf("rst_ovf_dut%0d", k), int'(ovf[k]), 0);
      last_done[k] = -1; busy_lo[k] = 0; busy_hi[k] = -1;
      held_q[k] = 8'h00; held_r[k] = 8'h00; held_dbz[k] = 1'b0; held_ovf[k] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb0.size() > 0 || sb1.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb0.size() + sb1.size());
    end
  endtask

  initial begin
    int e;
    int e2;
    int k;
    int a;
    int b;
    int gap;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; a_in[i] = 8'h00; b_in[i] = 8'h00;
      last_done[i] = -1; busy_lo[i] = 0; busy_hi[i] = -1;
      held_q[i] = 8'h00; held_r[i] = 8'h00; held_dbz[i] = 1'b0; held_ovf[i] = 1'b0;
    end
    do_reset();

    issue(0, 200, 7, 0, e);   drain();
    issue(1, 3, 2, 0, e);     drain();
    issue(0, 37, 0, 0, e);    drain();
    issue(1, 255, 1, 0, e);   drain();

    // Start while busy is ignored; start in the DONE cycle is accepted.
    issue(0, 200, 7, 0, e);
    issue(0, 9, 3, e + 2, e2);
    issue(0, 9, 3, e + 9, e2);
    drain();
    issue(1, 100, 7, 0, e);
    issue(1, 50, 3, e + 13, e2);
    drain();
    issue(0, 5, 0, 0, e);
    issue(0, 50, 6, e + 1, e2);
    drain();

    // Abort mid-RUN, then a fresh request on the first edge after release.
    issue(0, 77, 9, 0, e);
    while (cyc < e + 3) @(negedge clk);
    do_reset();
    issue(0, 100, 10, 0, e);
    drain();

    for (int i = 0; i < 80; i++) begin
      k   = int'($urandom_range(0, 1));
      a   = int'($urandom_range(0, 255));
      b   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 14));
      issue(k, a, b, cyc + 1 + gap, e);
    end
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
